// File: rtl/ray_dir_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ray_dir_gen_pkg
// Brief   : Shared FP27 format constants and scanner FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package ray_dir_gen_pkg;

    localparam int c_FP_W     = 27;
    localparam int c_EXP_W    = 8;
    localparam int c_MAN_W    = 18;
    localparam int c_SIGN_BIT = 26;
    localparam int c_EXP_MSB  = 25;
    localparam int c_EXP_LSB  = 18;
    localparam int c_MAN_MSB  = 17;

    localparam logic [c_FP_W-1:0]  c_FP_ZERO = '0;
    localparam logic [c_EXP_W-1:0] c_FP_BIAS = 8'd127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ray_dir_gen_int_to_fp27.sv
`default_nettype none
// ============================================================================
// Module  : int_to_fp27
// Brief   : Exact signed-integer to FP27 conversion with leading-one detect.
// Revision: 1.0 - initial release
// ============================================================================
module int_to_fp27
    import ray_dir_gen_pkg::*;
#(
    parameter int COORD_W = 12
) (
    input  logic signed [COORD_W-1:0] i_val,
    output logic        [c_FP_W-1:0]  o_fp
);

    localparam int c_P_W = $clog2(COORD_W);

    logic [COORD_W-1:0] w_mag;
    logic [c_P_W-1:0]   w_lead;
    logic [COORD_W-2:0] w_frac;
    logic [c_MAN_W-1:0] w_man;

    always_comb begin
        w_mag  = i_val[COORD_W-1] ? COORD_W'(-i_val) : COORD_W'(i_val);
        w_lead = '0;
        for (int i = 0; i < COORD_W; i++) begin
            if (w_mag[i]) w_lead = c_P_W'(i);
        end
        // Shift the leading one out of the top so the remaining bits are the fraction
        w_frac = (COORD_W-1)'(w_mag << (c_P_W'(COORD_W-1) - w_lead));
    end

    generate
        if (COORD_W-1 < c_MAN_W) begin : g_man_pad
            assign w_man = {w_frac, {(c_MAN_W-COORD_W+1){1'b0}}};
        end else begin : g_man_trunc
            assign w_man = w_frac[COORD_W-2 -: c_MAN_W];
        end
    endgenerate

    always_comb begin
        o_fp = c_FP_ZERO;
        if (w_mag != '0) begin
            o_fp[c_SIGN_BIT]          = i_val[COORD_W-1];
            o_fp[c_EXP_MSB:c_EXP_LSB] = c_FP_BIAS + c_EXP_W'(w_lead);
            o_fp[c_MAN_MSB:0]         = w_man;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ray_dir_gen.sv
`default_nettype none
// ============================================================================
// Module  : ray_dir_gen
// Brief   : Frame pixel scanner emitting camera-space ray directions (FP27).
// Revision: 1.0 - initial release
// ============================================================================
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int                WIDTH    = 640,
    parameter int                HEIGHT   = 480,
    parameter int                COORD_W  = 12,
    parameter logic [c_FP_W-1:0] FOCAL_FP = 27'h2200000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [c_FP_W-1:0]  o_dir_x,
    output logic [c_FP_W-1:0]  o_dir_y,
    output logic [c_FP_W-1:0]  o_dir_z,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic               o_last,
    output logic               o_busy
);

    localparam logic        [COORD_W-1:0] c_X_MAX  = COORD_W'(WIDTH-1);
    localparam logic        [COORD_W-1:0] c_Y_MAX  = COORD_W'(HEIGHT-1);
    localparam logic signed [COORD_W-1:0] c_HALF_W = COORD_W'(WIDTH/2);
    localparam logic signed [COORD_W-1:0] c_HALF_H = COORD_W'(HEIGHT/2);

    state_t                     r_state;
    logic        [COORD_W-1:0]  r_cnt_x;
    logic        [COORD_W-1:0]  r_cnt_y;

    logic                       r_s0_valid;
    logic                       r_s0_last;
    logic signed [COORD_W-1:0]  r_s0_off_x;
    logic signed [COORD_W-1:0]  r_s0_off_y;
    logic        [COORD_W-1:0]  r_s0_pix_x;
    logic        [COORD_W-1:0]  r_s0_pix_y;

    logic                       r_valid;
    logic                       r_last;
    logic        [c_FP_W-1:0]   r_dir_x;
    logic        [c_FP_W-1:0]   r_dir_y;
    logic        [c_FP_W-1:0]   r_dir_z;
    logic        [COORD_W-1:0]  r_pix_x;
    logic        [COORD_W-1:0]  r_pix_y;

    logic                       w_adv;
    logic                       w_issue;
    logic                       w_done;
    logic                       w_iss_last;
    logic        [COORD_W-1:0]  w_iss_x;
    logic        [COORD_W-1:0]  w_iss_y;
    logic        [COORD_W-1:0]  w_nxt_x;
    logic        [COORD_W-1:0]  w_nxt_y;
    logic        [c_FP_W-1:0]   w_fp_x;
    logic        [c_FP_W-1:0]   w_fp_y;

    // The whole pipe moves only when the output slot is empty or being taken
    assign w_adv      = !r_valid || i_ready;
    assign w_issue    = w_adv && ((r_state == IDLE && i_start) || r_state == RUN);
    assign w_done     = (r_state == DRAIN) && r_valid && i_ready && r_last;
    assign w_iss_x    = (r_state == RUN) ? r_cnt_x : '0;
    assign w_iss_y    = (r_state == RUN) ? r_cnt_y : '0;
    assign w_iss_last = (w_iss_x == c_X_MAX) && (w_iss_y == c_Y_MAX);
    assign w_nxt_x    = (w_iss_x == c_X_MAX) ? '0 : w_iss_x + 1'b1;
    assign w_nxt_y    = (w_iss_x == c_X_MAX) ? w_iss_y + 1'b1 : w_iss_y;

    int_to_fp27 #(.COORD_W(COORD_W)) u_cvt_x (.i_val(r_s0_off_x), .o_fp(w_fp_x));
    int_to_fp27 #(.COORD_W(COORD_W)) u_cvt_y (.i_val(r_s0_off_y), .o_fp(w_fp_y));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt_x    <= '0;
            r_cnt_y    <= '0;
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_off_x <= '0;
            r_s0_off_y <= '0;
            r_s0_pix_x <= '0;
            r_s0_pix_y <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_dir_x    <= '0;
            r_dir_y    <= '0;
            r_dir_z    <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
        end else begin
            if (w_issue) begin
                r_cnt_x <= w_iss_last ? '0 : w_nxt_x;
                r_cnt_y <= w_iss_last ? '0 : w_nxt_y;
                r_state <= w_iss_last ? DRAIN : RUN;
            end else if (w_done) begin
                r_state <= IDLE;
            end

            if (w_adv) begin
                r_s0_valid <= w_issue;
                if (w_issue) begin
                    r_s0_off_x <= $signed(w_iss_x) - c_HALF_W;
                    r_s0_off_y <= c_HALF_H - $signed(w_iss_y);
                    r_s0_pix_x <= w_iss_x;
                    r_s0_pix_y <= w_iss_y;
                    r_s0_last  <= w_iss_last;
                end
                r_valid <= r_s0_valid;
                if (r_s0_valid) begin
                    r_dir_x <= w_fp_x;
                    r_dir_y <= w_fp_y;
                    r_dir_z <= FOCAL_FP;
                    r_pix_x <= r_s0_pix_x;
                    r_pix_y <= r_s0_pix_y;
                    r_last  <= r_s0_last;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_dir_x = r_dir_x;
    assign o_dir_y = r_dir_y;
    assign o_dir_z = r_dir_z;
    assign o_pix_x = r_pix_x;
    assign o_pix_y = r_pix_y;
    assign o_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ray_dir_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_ray_dir_gen
// Brief   : Directed self-checking bench for ray_dir_gen and int_to_fp27.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ray_dir_gen;

    localparam int W_B = 20;
    localparam int H_B = 6;
    localparam int N_B = W_B * H_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, start_a, ready_a, valid_a, last_a, busy_a;
    logic [26:0] dir_x_a, dir_y_a, dir_z_a;
    logic [11:0] pix_x_a, pix_y_a;
    logic        rst_b_n, start_b, ready_b, valid_b, last_b, busy_b;
    logic [26:0] dir_x_b, dir_y_b, dir_z_b;
    logic [11:0] pix_x_b, pix_y_b;
    logic signed [11:0] sw_val;
    logic [26:0] sw_fp;

    ray_dir_gen #(.WIDTH(640), .HEIGHT(480), .COORD_W(12), .FOCAL_FP(27'h2200000)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_start(start_a), .i_ready(ready_a),
        .o_valid(valid_a), .o_dir_x(dir_x_a), .o_dir_y(dir_y_a), .o_dir_z(dir_z_a),
        .o_pix_x(pix_x_a), .o_pix_y(pix_y_a), .o_last(last_a), .o_busy(busy_a));

    ray_dir_gen #(.WIDTH(W_B), .HEIGHT(H_B), .COORD_W(12), .FOCAL_FP(27'h2200000)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_start(start_b), .i_ready(ready_b),
        .o_valid(valid_b), .o_dir_x(dir_x_b), .o_dir_y(dir_y_b), .o_dir_z(dir_z_b),
        .o_pix_x(pix_x_b), .o_pix_y(pix_y_b), .o_last(last_b), .o_busy(busy_b));

    int_to_fp27 #(.COORD_W(12)) u_cvt (.i_val(sw_val), .o_fp(sw_fp));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: normalise by repeated shifting rather than a priority scan
    function automatic logic [26:0] ref_fp(input int v);
        int a, e;
        logic [26:0] r;
        if (v == 0) return 27'h0;
        a = (v < 0) ? -v : v;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        r[26]    = (v < 0);
        r[25:18] = 8'(127 + e);
        r[17:0]  = 18'((a - (1 << e)) << (18 - e));
        return r;
    endfunction

    int          idx_b = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [26:0] hold_x;
    logic [23:0] hold_pix;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", valid_b, 1);
                check("hold_dir_x", dir_x_b, hold_x);
                check("hold_pix", {pix_y_b, pix_x_b}, hold_pix);
            end
            if (valid_b && ready_b) begin
                check("seq_pix_x", pix_x_b, idx_b % W_B);
                check("seq_pix_y", pix_y_b, idx_b / W_B);
                check("seq_dir_x", dir_x_b, ref_fp((idx_b % W_B) - W_B / 2));
                check("seq_dir_y", dir_y_b, ref_fp(H_B / 2 - idx_b / W_B));
                check("seq_dir_z", dir_z_b, 27'h2200000);
                check("seq_last", last_b, (idx_b == N_B - 1));
                idx_b++;
            end
            prev_stall = valid_b && !ready_b;
            hold_x     = dir_x_b;
            hold_pix   = {pix_y_b, pix_x_b};
        end
    end

    initial begin
        int cnt;
        rst_a_n = 1'b0; start_a = 1'b0; ready_a = 1'b0;
        rst_b_n = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        sw_val  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_a, 0);
        check("rst_last", last_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_dir", {dir_x_a[15:0], dir_y_a[15:0]}, 0);
        check("rst_dir_z", dir_z_a, 0);
        check("rst_pix", {pix_y_a, pix_x_a}, 0);
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // First word latency and value on the full-size scanner
        ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("lat_n1_valid", valid_a, 0);
        check("lat_n1_busy", busy_a, 1);
        @(posedge clk); #1;
        check("first_valid", valid_a, 1);
        check("first_dir_x", dir_x_a, 27'h61D0000);
        check("first_dir_y", dir_y_a, 27'h21B8000);
        check("first_dir_z", dir_z_a, 27'h2200000);
        check("first_pix", {pix_y_a, pix_x_a}, 0);
        check("first_last", last_a, 0);

        // Abort at pixel (100,5)
        for (int i = 0; i < 5000 && !(valid_a && pix_x_a == 12'd100 && pix_y_a == 12'd5); i++) begin
            @(posedge clk); #1;
        end
        check("reach_100_5", {valid_a, pix_y_a, pix_x_a}, {1'b1, 12'd5, 12'd100});
        check("reach_dir_x", dir_x_a, ref_fp(100 - 320));
        #2 rst_a_n = 1'b0;
        #1;
        check("abort_valid", valid_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_last", last_a, 0);
        check("abort_dir_x", dir_x_a, 0);
        check("abort_dir_yz", {dir_y_a[15:0], dir_z_a[15:0]}, 0);
        check("abort_pix", {pix_y_a, pix_x_a}, 0);
        @(posedge clk); #1 rst_a_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid_a || busy_a) cnt++;
        end
        check("post_rst_quiet", cnt, 0);
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(posedge clk); #1;
        check("restart_valid", valid_a, 1);
        check("restart_pix", {pix_y_a, pix_x_a}, 0);
        check("restart_dir_x", dir_x_a, 27'h61D0000);
        rst_a_n = 1'b0;

        // Small frame, no backpressure: words in consecutive cycles
        idx_b = 0; mon_en = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < N_B; i++) begin
            check("consec_valid", valid_b, 1);
            if (i == 10) check("dir_x_zero", dir_x_b, 27'h0);
            if (i == 11) check("dir_x_one", dir_x_b, 27'h1FC0000);
            if (i == N_B - 1) begin
                check("last_flag", last_b, 1);
                check("last_pix", {pix_y_b, pix_x_b}, {12'd5, 12'd19});
                check("last_dir_x", dir_x_b, 27'h2088000);
                check("last_dir_y", dir_y_b, 27'h6000000);
            end
            @(posedge clk); #1;
        end
        check("end_busy", busy_b, 0);
        check("end_valid", valid_b, 0);
        check("frame_count", idx_b, N_B);

        // Random backpressure
        idx_b = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!busy_b) break;
            ready_b = 1'($urandom_range(0, 1));
        end
        check("bp_done", busy_b, 0);
        check("bp_count", idx_b, N_B);
        ready_b = 1'b1;

        // Stray starts: mid-frame and together with the final acceptance
        idx_b = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (!busy_b) break;
            start_b = (i == 30) || (valid_b && last_b);
        end
        start_b = 1'b0;
        check("stray_done", busy_b, 0);
        check("stray_count", idx_b, N_B);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_b || busy_b) cnt++;
        end
        check("stray_no_restart", cnt, 0);
        mon_en = 1'b0;

        // Converter sweep
        for (int v = -2048; v <= 2047; v++) begin
            sw_val = 12'(v);
            #1;
            check("cvt_sweep", sw_fp, ref_fp(v));
        end
        sw_val = 12'sd0;
        #1;
        check("cvt_zero", sw_fp, 27'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_dir_gen.md
Name: ray_dir_gen

Overview:
- Per-frame pixel scanner at the head of the raymarch pipeline.
- For each pixel it emits an unnormalised camera-space ray direction as three 27-bit floats: x offset, y offset, and a focal constant.
- Output feeds the camera-rotation VEC_3x3_mult and then VEC_normalize.
- Uses a valid/ready handshake so downstream stalls propagate back to the scan counters.

Parameters:
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- COORD_W, 12, counter/offset width in bits; requires WIDTH, HEIGHT < 2^(COORD_W-1)
- FOCAL_FP, 27'h2200000, z component (512.0), constant for every pixel

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  pulse; begins a frame when idle
- i_ready  in  1  downstream accepts the current output
- o_valid  out  1  output word valid
- o_dir_x  out  27  float(x - WIDTH/2)
- o_dir_y  out  27  float(HEIGHT/2 - y)
- o_dir_z  out  27  FOCAL_FP
- o_pix_x  out  COORD_W  pixel x tag
- o_pix_y  out  COORD_W  pixel y tag
- o_last  out  1  marks the final pixel of the frame (qualified by o_valid)
- o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Float format: bit 26 = sign, [25:18] = exponent with bias 127, [17:0] = mantissa with hidden 1. Zero is all zeros.
- Reset (async assert, sync release): state IDLE; counters 0; all outputs 0 (o_valid, o_last, o_busy, dir, pix).
- State machine:
  - IDLE: i_start moves to RUN and loads issue stage with (0,0). i_start is ignored in RUN and DRAIN.
  - RUN: each un-stalled cycle issues the current (x,y) into stage 0.
    - x increments; at WIDTH-1 it wraps to 0 and y increments.
    - Issuing (WIDTH-1, HEIGHT-1) moves to DRAIN.
  - DRAIN: no new issues. Returns to IDLE in the cycle the o_last word is accepted (o_valid & i_ready & o_last).
- Pipeline:
  - Stage 0 registers the signed offsets x-WIDTH/2 and HEIGHT/2-y plus the pixel tags.
  - Stage 1 (output register) holds the int_to_fp27 results, tags and last flag.
- Latency: i_start sampled at cycle n gives first o_valid at n+2.
- Throughput: 1 pixel/cycle while i_ready is high; a full frame is WIDTH*HEIGHT accepted words.
- Stall: when o_valid & !i_ready, all stages and counters freeze. Output data is held stable until accepted; no word is dropped or duplicated.
- o_valid deasserts only after acceptance with no new word behind it.
- Conversion is exact for |v| < 2^COORD_W:
  - v = 0 gives 0.
  - Otherwise sign = v<0, exp = 127 + p (p = leading-one index of |v|), mantissa = bits of |v| below the leading one, left-aligned into 18 bits.
- Reset mid-frame aborts immediately; no partial-frame output follows reset release.
- Simultaneous i_start and the final acceptance in DRAIN: the start is ignored (FSM is not yet IDLE).

Decomposition:
- Shared package: FP27 width constant, FP_ZERO, FP bias (127), field index constants, FSM state enum {IDLE, RUN, DRAIN}.
- One combinational sub-module, int_to_fp27: signed COORD_W integer in, 27-bit float out, containing the leading-one detector.
- ray_dir_gen holds the FSM, counters and two-stage handshake pipeline.

Test Plan:
- Reset, then i_start with i_ready=1 -> o_valid rises 2 cycles later; first word dir_x=27'h61D0000 (-320.0), dir_y=27'h21B8000 (240.0), dir_z=27'h2200000, pix=(0,0).
- Continuous i_ready=1, full frame -> exactly 307200 valid words in consecutive cycles.
  - pix (320,y) gives dir_x=0; (321,y) gives 27'h1FC0000 (1.0).
  - Last word (639,479), o_last=1, dir_x=+319.0, dir_y=-239.0; o_busy falls the next cycle.
- Random i_ready backpressure -> data held stable while stalled; sequence of pix tags is identical to the no-stall run, with no gaps or repeats.
- i_start pulsed mid-frame -> ignored; frame count and ordering unchanged.
- i_rst_n asserted at pixel (100,5) with o_valid=1 -> all outputs 0 immediately; after release no output until a new i_start, which restarts at (0,0).
- int_to_fp27 sweep over all offsets -2048..2047 -> matches reference conversion bit-exactly; 0 maps to 27'h0.
